// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: port indices, command encoding
// and the read-return tag carried alongside each in-flight read.
package sram_arb_pkg;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_RD   = 2'd1,
        CMD_WR   = 2'd2
    } cmd_e;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    function automatic cmd_e cmd_of(input logic gnt, input logic wr);
        if (!gnt) return CMD_IDLE;
        return wr ? CMD_WR : CMD_RD;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant selection between port A and port B.
// Pointer and wait-counter state live in the parent; this only decides.
module sram_arb_pick #(
    parameter int PRIO_A = 0
) (
    input  logic elig_a,
    input  logic elig_b,
    input  logic last_b,
    input  logic wait_sat,
    output logic gnt_a,
    output logic gnt_b
);

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (elig_a && elig_b) begin
            if (PRIO_A != 0) begin
                // A owns ties until B has waited long enough
                if (wait_sat) gnt_b = 1'b1;
                else          gnt_a = 1'b1;
            end else begin
                if (last_b) gnt_a = 1'b1;
                else        gnt_b = 1'b1;
            end
        end else begin
            gnt_a = elig_a;
            gnt_b = elig_b;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port front end for a single-port synchronous SRAM: one command per cycle,
// registered strobes, and read data routed back to the issuing port 3 cycles later.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int dw      = 8,
    parameter int aw      = 10,
    parameter int PRIO_A  = 0,
    parameter int MAXWAIT = 15
) (
    input  logic          i_MCLK,
    input  logic          i_RST_n,

    input  logic          i_A_REQ,
    input  logic          i_A_WR,
    input  logic [aw-1:0] i_A_ADDR,
    input  logic [dw-1:0] i_A_DIN,
    output logic          o_A_ACK,
    output logic          o_A_RVALID,
    output logic [dw-1:0] o_A_RDATA,

    input  logic          i_B_REQ,
    input  logic          i_B_WR,
    input  logic [aw-1:0] i_B_ADDR,
    input  logic [dw-1:0] i_B_DIN,
    output logic          o_B_ACK,
    output logic          o_B_RVALID,
    output logic [dw-1:0] o_B_RDATA,

    output logic [aw-1:0] o_SRAM_ADDR,
    output logic [dw-1:0] o_SRAM_DIN,
    output logic          o_SRAM_WR_n,
    output logic          o_SRAM_RD_n,
    input  logic [dw-1:0] i_SRAM_DOUT
);

    localparam int            CW   = $clog2(MAXWAIT + 1);
    localparam logic [CW-1:0] WMAX = CW'(MAXWAIT);

    logic          last_b;
    logic [CW-1:0] wait_cnt;
    logic          wait_sat;
    logic          elig_a, elig_b;
    logic          gnt_a, gnt_b, gnt, gnt_wr;
    cmd_e          cmd;
    rd_tag_t [2:1] tag_pipe;

    // A port that was just acked is masked for one cycle so the requester
    // has time to drop or change its request.
    assign elig_a   = i_A_REQ & ~o_A_ACK;
    assign elig_b   = i_B_REQ & ~o_B_ACK;
    assign wait_sat = (wait_cnt == WMAX);

    sram_arb_pick #(.PRIO_A(PRIO_A)) u_pick (
        .elig_a   (elig_a),
        .elig_b   (elig_b),
        .last_b   (last_b),
        .wait_sat (wait_sat),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b)
    );

    assign gnt    = gnt_a | gnt_b;
    assign gnt_wr = gnt_b ? i_B_WR : i_A_WR;
    assign cmd    = cmd_of(gnt, gnt_wr);

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            o_A_ACK     <= 1'b0;
            o_B_ACK     <= 1'b0;
            o_SRAM_WR_n <= 1'b1;
            o_SRAM_RD_n <= 1'b1;
            o_SRAM_ADDR <= '0;
            o_SRAM_DIN  <= '0;
            last_b      <= 1'b1;
            wait_cnt    <= '0;
        end else begin
            o_A_ACK     <= gnt_a;
            o_B_ACK     <= gnt_b;
            o_SRAM_WR_n <= (cmd != CMD_WR);
            o_SRAM_RD_n <= (cmd != CMD_RD);
            if (gnt) begin
                o_SRAM_ADDR <= gnt_b ? i_B_ADDR : i_A_ADDR;
                o_SRAM_DIN  <= gnt_b ? i_B_DIN  : i_A_DIN;
                last_b      <= gnt_b;
            end
            if (!i_B_REQ || gnt_b)
                wait_cnt <= '0;
            else if (elig_b && !wait_sat)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Stage 1 lines up with the SRAM sampling the command, stage 2 with DOUT.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            tag_pipe   <= '0;
            o_A_RVALID <= 1'b0;
            o_B_RVALID <= 1'b0;
            o_A_RDATA  <= '0;
            o_B_RDATA  <= '0;
        end else begin
            tag_pipe[1] <= '{valid: (cmd == CMD_RD), port: (gnt_b ? PORT_B : PORT_A)};
            tag_pipe[2] <= tag_pipe[1];
            o_A_RVALID  <= tag_pipe[2].valid && (tag_pipe[2].port == PORT_A);
            o_B_RVALID  <= tag_pipe[2].valid && (tag_pipe[2].port == PORT_B);
            if (tag_pipe[2].valid && tag_pipe[2].port == PORT_A) o_A_RDATA <= i_SRAM_DOUT;
            if (tag_pipe[2].valid && tag_pipe[2].port == PORT_B) o_B_RDATA <= i_SRAM_DOUT;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a round-robin and a priority instance run side by side
// against a transaction-level model (grant order, memory contents, return timing).
module tb_sram_arbiter;

    localparam int DW = 8;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // [instance][port], instance 0 = round-robin, 1 = PRIO_A with MAXWAIT=3
    logic          req   [2][2];
    logic          wr    [2][2];
    logic [AW-1:0] addr  [2][2];
    logic [DW-1:0] din   [2][2];
    logic          ack   [2][2];
    logic          rv    [2][2];
    logic [DW-1:0] rdata [2][2];
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_din  [2];
    logic [DW-1:0] s_dout [2];
    logic          s_wr_n [2];
    logic          s_rd_n [2];
    logic [DW-1:0] sram   [2][1024];

    sram_arbiter #(.dw(DW), .aw(AW), .PRIO_A(0), .MAXWAIT(15)) u_rr (
        .i_MCLK(clk), .i_RST_n(rst_n),
        .i_A_REQ(req[0][0]), .i_A_WR(wr[0][0]), .i_A_ADDR(addr[0][0]), .i_A_DIN(din[0][0]),
        .o_A_ACK(ack[0][0]), .o_A_RVALID(rv[0][0]), .o_A_RDATA(rdata[0][0]),
        .i_B_REQ(req[0][1]), .i_B_WR(wr[0][1]), .i_B_ADDR(addr[0][1]), .i_B_DIN(din[0][1]),
        .o_B_ACK(ack[0][1]), .o_B_RVALID(rv[0][1]), .o_B_RDATA(rdata[0][1]),
        .o_SRAM_ADDR(s_addr[0]), .o_SRAM_DIN(s_din[0]), .o_SRAM_WR_n(s_wr_n[0]),
        .o_SRAM_RD_n(s_rd_n[0]), .i_SRAM_DOUT(s_dout[0])
    );

    sram_arbiter #(.dw(DW), .aw(AW), .PRIO_A(1), .MAXWAIT(3)) u_pr (
        .i_MCLK(clk), .i_RST_n(rst_n),
        .i_A_REQ(req[1][0]), .i_A_WR(wr[1][0]), .i_A_ADDR(addr[1][0]), .i_A_DIN(din[1][0]),
        .o_A_ACK(ack[1][0]), .o_A_RVALID(rv[1][0]), .o_A_RDATA(rdata[1][0]),
        .i_B_REQ(req[1][1]), .i_B_WR(wr[1][1]), .i_B_ADDR(addr[1][1]), .i_B_DIN(din[1][1]),
        .o_B_ACK(ack[1][1]), .o_B_RVALID(rv[1][1]), .o_B_RDATA(rdata[1][1]),
        .o_SRAM_ADDR(s_addr[1]), .o_SRAM_DIN(s_din[1]), .o_SRAM_WR_n(s_wr_n[1]),
        .o_SRAM_RD_n(s_rd_n[1]), .i_SRAM_DOUT(s_dout[1])
    );

    // Synchronous single-port SRAM with 1-cycle registered read
    for (genvar g = 0; g < 2; g++) begin : g_sram
        always @(posedge clk) begin
            if (!s_wr_n[g]) sram[g][s_addr[g]] <= s_din[g];
            if (!s_rd_n[g]) s_dout[g] <= sram[g][s_addr[g]];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rd_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            prio_of [2] = '{0, 1};
    int            maxw_of [2] = '{15, 3};
    logic          exp_ack   [2][2];
    logic          exp_rv    [2][2];
    logic [DW-1:0] exp_rdata [2][2];
    logic          exp_wr_n  [2];
    logic          exp_rd_n  [2];
    logic [AW-1:0] exp_addr  [2];
    logic [DW-1:0] exp_din   [2];
    logic          last_b    [2];
    int            wcnt      [2];
    logic [DW-1:0] ref_mem   [2][1024];
    rd_t           rq        [2][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                exp_ack[i][p]   = 1'b0;
                exp_rv[i][p]    = 1'b0;
                exp_rdata[i][p] = '0;
            end
            exp_wr_n[i] = 1'b1;
            exp_rd_n[i] = 1'b1;
            exp_addr[i] = '0;
            exp_din[i]  = '0;
            last_b[i]   = 1'b1;
            wcnt[i]     = 0;
            rq[i].delete();
        end
    endtask

    // Predict the effect of the coming rising edge from the inputs now applied.
    task automatic model_step();
        cyc++;
        for (int i = 0; i < 2; i++) begin
            logic ea, eb;
            int   g;
            ea = req[i][0] && !exp_ack[i][0];
            eb = req[i][1] && !exp_ack[i][1];
            g  = -1;
            if (ea && eb) begin
                if (prio_of[i] != 0) g = (wcnt[i] >= maxw_of[i]) ? 1 : 0;
                else                 g = last_b[i] ? 0 : 1;
            end else if (ea) g = 0;
            else if (eb)     g = 1;
            if (!req[i][1] || g == 1)              wcnt[i] = 0;
            else if (eb && wcnt[i] < maxw_of[i])   wcnt[i]++;
            for (int p = 0; p < 2; p++) exp_ack[i][p] = (g == p);
            if (g >= 0) begin
                last_b[i]   = (g == 1);
                exp_addr[i] = addr[i][g];
                exp_din[i]  = din[i][g];
                exp_wr_n[i] = !wr[i][g];
                exp_rd_n[i] = wr[i][g];
                if (wr[i][g]) ref_mem[i][addr[i][g]] = din[i][g];
                else          rq[i].push_back('{due: cyc + 2, port: g, data: ref_mem[i][addr[i][g]]});
            end else begin
                exp_wr_n[i] = 1'b1;
                exp_rd_n[i] = 1'b1;
            end
            for (int p = 0; p < 2; p++) exp_rv[i][p] = 1'b0;
            if (rq[i].size() > 0 && rq[i][0].due == cyc) begin
                rd_t r;
                r = rq[i].pop_front();
                exp_rv[i][r.port]    = 1'b1;
                exp_rdata[i][r.port] = r.data;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("c%0d i%0d p%0d ack", cyc, i, p), 32'(ack[i][p]), 32'(exp_ack[i][p]));
                chk($sformatf("c%0d i%0d p%0d rvalid", cyc, i, p), 32'(rv[i][p]), 32'(exp_rv[i][p]));
                chk($sformatf("c%0d i%0d p%0d rdata", cyc, i, p), 32'(rdata[i][p]), 32'(exp_rdata[i][p]));
            end
            chk($sformatf("c%0d i%0d wr_n", cyc, i), 32'(s_wr_n[i]), 32'(exp_wr_n[i]));
            chk($sformatf("c%0d i%0d rd_n", cyc, i), 32'(s_rd_n[i]), 32'(exp_rd_n[i]));
            chk($sformatf("c%0d i%0d addr", cyc, i), 32'(s_addr[i]), 32'(exp_addr[i]));
            chk($sformatf("c%0d i%0d din", cyc, i), 32'(s_din[i]), 32'(exp_din[i]));
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_req(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        for (int i = 0; i < 2; i++) begin
            req[i][p]  = 1'b1;
            wr[i][p]   = w;
            addr[i][p] = a;
            din[i][p]  = d;
        end
    endtask

    task automatic drop_all();
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++) req[i][p] = 1'b0;
    endtask

    // Requesters hold until acked, then release; then let returns drain.
    task automatic run_until_done();
        for (int n = 0; n < 20; n++) begin
            logic busy;
            tick();
            busy = 1'b0;
            for (int i = 0; i < 2; i++)
                for (int p = 0; p < 2; p++) begin
                    if (exp_ack[i][p]) req[i][p] = 1'b0;
                    busy |= req[i][p];
                end
            if (!busy) break;
        end
        repeat (3) tick();
    endtask

    function automatic logic [AW-1:0] addr_of(input int k);
        return (k < 8) ? AW'(k) : AW'(10'h3F0 + k);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++) begin
                req[i][p] = 1'b0; wr[i][p] = 1'b0; addr[i][p] = '0; din[i][p] = '0;
            end
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // A write then A read of 0x012
        set_req(0, 1'b1, 10'h012, 8'h5A);
        run_until_done();
        set_req(0, 1'b0, 10'h012, 8'h00);
        run_until_done();

        // preload the random-address pool from both ports at once
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1'b1, addr_of(2 * k), 8'($urandom));
            set_req(1, 1'b1, addr_of(2 * k + 1), 8'($urandom));
            run_until_done();
        end

        // both ports request continuously: one strobe per cycle, alternating
        set_req(0, 1'b0, 10'h001, 8'h00);
        set_req(1, 1'b0, 10'h002, 8'h00);
        repeat (12) tick();
        drop_all();
        repeat (4) tick();

        // top-of-range write by B then read by A, then simultaneous write/read
        set_req(1, 1'b1, 10'h3FF, 8'hC3);
        run_until_done();
        set_req(0, 1'b0, 10'h3FF, 8'h00);
        run_until_done();
        set_req(1, 1'b1, 10'h3FE, 8'h96);
        set_req(0, 1'b0, 10'h3FE, 8'h00);
        run_until_done();

        // random traffic, including requests withdrawn before their ack
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < 2; i++)
                for (int p = 0; p < 2; p++) begin
                    if (!req[i][p] || exp_ack[i][p]) begin
                        req[i][p]  = ($urandom_range(0, 3) != 0);
                        wr[i][p]   = 1'($urandom_range(0, 1));
                        addr[i][p] = addr_of($urandom_range(0, 15));
                        din[i][p]  = 8'($urandom);
                    end else if ($urandom_range(0, 15) == 0) begin
                        req[i][p] = 1'b0;
                    end
                end
            tick();
        end
        drop_all();
        repeat (4) tick();

        // reset while a read is in flight: strobes drop at once, no return
        set_req(0, 1'b0, 10'h3FF, 8'h00);
        tick();
        drop_all();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        repeat (4) tick();

        // first tie after reset goes to A
        set_req(0, 1'b0, 10'h3FE, 8'h00);
        set_req(1, 1'b0, 10'h3FF, 8'h00);
        run_until_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
